// File: rtl/sr_cmd_encoder.sv
// Command-to-pulse encoder driving an SR storage element: each accepted bit becomes a timed set or reset pulse plus a guard gap.
// Optional q readback checking is enabled by defining SR_READBACK_EN.
module sr_cmd_encoder #(
   parameter int PULSE_W        = 2,
   parameter int GAP_W          = 1,
   parameter bit SKIP_REDUNDANT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic in_data,
   output logic in_ready,
   output logic s,
   output logic r,
   output logic busy,
   input  logic q_fb,
   output logic mismatch
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t     r_state;
   logic [3:0] r_cnt;
   logic       r_s;
   logic       r_r;
   logic       r_ready;
   logic       r_busy;
   logic       r_shadow_vld;
   logic       r_shadow;
   logic       r_tgt;

   logic       w_accept;
   logic       w_pulse;
   logic       w_drive_exit;

   assign w_accept     = in_valid && r_ready;
   assign w_pulse      = !SKIP_REDUNDANT || !r_shadow_vld || (in_data != r_shadow);
   assign w_drive_exit = (r_state == ST_DRIVE) && (r_cnt == 4'd0);

   // Control path: s/r/ready/busy are registered so s and r can never glitch together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 4'd0;
         r_s          <= 1'b0;
         r_r          <= 1'b0;
         r_ready      <= 1'b1;
         r_busy       <= 1'b0;
         r_shadow_vld <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept && w_pulse) begin
                  r_state <= ST_DRIVE;
                  r_cnt   <= 4'(PULSE_W - 1);
                  r_s     <= in_data;
                  r_r     <= !in_data;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            ST_DRIVE: begin
               if (r_cnt == 4'd0) begin
                  r_s          <= 1'b0;
                  r_r          <= 1'b0;
                  r_shadow_vld <= 1'b1;
                  if (GAP_W == 0) begin
                     r_state <= ST_IDLE;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= ST_GAP;
                     r_cnt   <= 4'(GAP_W - 1);
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_GAP: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_s     <= 1'b0;
               r_r     <= 1'b0;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // The shadow mirrors the SR element only once a full pulse has completed.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tgt <= in_data;
      end
      if (w_drive_exit) begin
         r_shadow <= r_tgt;
      end
   end

   assign s        = r_s;
   assign r        = r_r;
   assign in_ready = r_ready;
   assign busy     = r_busy;

`ifdef SR_READBACK_EN
   logic r_chk_pend;
   logic r_mismatch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chk_pend <= 1'b0;
         r_mismatch <= 1'b0;
      end else begin
         r_chk_pend <= w_drive_exit;
         if (r_chk_pend && (q_fb != r_shadow)) begin
            r_mismatch <= 1'b1;
         end
      end
   end

   assign mismatch = r_mismatch;
`else
   logic w_unused_q_fb;

   assign w_unused_q_fb = q_fb;
   assign mismatch      = 1'b0;
`endif

   a_no_set_and_reset : assert property (@(posedge clk) !(r_s && r_r));

endmodule

// File: doc/sr_cmd_encoder.md
Name: sr_cmd_encoder

Overview:
Upstream driver for the SR-based storage element (s/r/clk/q). It accepts single-bit data commands over a valid/ready handshake and converts each one into a timed set or reset pulse. The pulse is followed by a guard gap. The block guarantees s and r are never high together, so the SR element only sees legal set, reset or hold inputs.

Parameters:
PULSE_W, 2, cycles s or r is held high per command; legal 1..15, 4-bit counter
GAP_W, 1, cycles s=r=0 after each pulse before the next accept; legal 0..15
SKIP_REDUNDANT, 1, when 1, a command equal to the last driven value is accepted without pulsing

Ports:
clk  input  1  rising-edge clock, shared with the downstream SR element
rst  input  1  asynchronous, active-high reset
in_valid  input  1  command valid
in_data  input  1  target value: 1 = set, 0 = reset
in_ready  output  1  block can accept a command this cycle
s  output  1  set drive to the SR element (registered)
r  output  1  reset drive to the SR element (registered)
busy  output  1  high whenever state != IDLE
q_fb  input  1  q readback from the SR element (used only with the optional feature)
mismatch  output  1  sticky readback error flag

Behaviour:
- Reset (asynchronous, immediate, including mid-pulse):
  - s=0, r=0, busy=0, mismatch=0, in_ready=1 once rst is low.
  - State -> IDLE, counter=0.
  - shadow_valid=0. The SR element has no reset, so its state is unknown.
- States:
  - IDLE: in_ready=1, s=r=0.
  - DRIVE: s=tgt, r=~tgt.
  - GAP: s=r=0, in_ready=0.
- Accept: in_valid && in_ready at a rising edge (edge E0); tgt <= in_data.
  - Pulse path: taken if SKIP_REDUNDANT=0, or shadow_valid=0, or in_data != shadow. Go to DRIVE.
  - Skip path: otherwise stay in IDLE. No pulse; in_ready stays 1.
- DRIVE:
  - Active for PULSE_W cycles (edges E0..E(PULSE_W-1)).
  - At edge E(PULSE_W): shadow <= tgt, shadow_valid <= 1, then go to GAP.
  - If GAP_W=0, go directly to IDLE instead.
- GAP: lasts GAP_W cycles, then IDLE. in_ready returns high after edge E(PULSE_W+GAP_W).
- Throughput: at most one pulsed command per PULSE_W+GAP_W+1 cycles. Skipped commands cost 1 cycle.
- Invariant: s&r == 0 in every cycle, including reset assertion and release.
- in_data is sampled only at accept. Changes while in_ready=0 are ignored.
- in_valid may be held high across commands. The next command is accepted on the first cycle in_ready=1.
- Illegal PULSE_W=0 is not supported (implementation may assert in simulation).

Optional Feature:
Macro SR_READBACK_EN.
- Defined:
  - On DRIVE exit, set chk_pend.
  - At the next rising edge, whatever the state, compare q_fb with shadow.
  - On inequality, set mismatch=1. mismatch is sticky until rst; chk_pend clears.
- Undefined: q_fb is ignored and mismatch is tied to 0. Handshake and pulse timing are identical in both builds.

Test Plan:
1. PULSE_W=2, GAP_W=1; after rst, in_valid=1, in_data=1 accepted at E0 -> s=1, r=0 for the cycles after E0 and E1; s=r=0 after E2; in_ready=1 after E3.
2. Continue from 1, send in_data=1 with SKIP_REDUNDANT=1 -> accepted in one cycle, s=r=0 throughout, busy stays 0.
3. in_valid held at 1 with in_data 1 then 0 back-to-back -> second command accepted at the first in_ready=1 edge; r=1 for 2 cycles; s&r never 1 (checked every cycle).
4. Assert rst during the second DRIVE cycle -> s drops to 0 before the next edge, in_ready=1; the next in_data=0 still pulses r, because shadow_valid=0.
5. SR_READBACK_EN defined, q_fb forced to 0, send in_data=1 -> mismatch=1 one edge after DRIVE exits and stays high until rst; same run without the macro gives mismatch=0.
6. in_valid=0 for 20 cycles after reset -> s=r=0, busy=0, in_ready=1 constantly.
